mgt01_mp_reg_file: RTL

Parametrised multi-port integer register file for the next MicroGT core generation.
- Configurable width, depth, read-port count and write-port count.
- Per-register pending scoreboard tracks long-latency producers (divider, FPU converts).
- Post-reset hardware sweep clears the array.
- Sits between decode (reads, reservations) and writeback (writes, scoreboard release).

---
 rtl/mgt01_mp_reg_file_pkg.sv | 26 ++
 rtl/mgt01_rf_scoreboard.sv | 55 +++++
 rtl/mgt01_mp_reg_file.sv | 115 +++++++++++
 3 files changed

// File: rtl/mgt01_mp_reg_file_pkg.sv
// Shared types and constants for the MicroGT multi-port register file.
// The optional write-to-read forwarding is enabled by MGT01_REGFILE_BYPASS_EN.
package mgt01_mp_reg_file_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_N_REGS = 32;
  localparam int DEF_N_RD   = 2;
  localparam int DEF_N_WR   = 2;
  localparam int DEF_ADDR_W = $clog2(DEF_N_REGS);

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] data_bus_t;

  typedef reg_addr_t [DEF_N_RD-1:0] rd_addr_arr_t;
  typedef data_bus_t [DEF_N_RD-1:0] rd_data_arr_t;
  typedef reg_addr_t [DEF_N_WR-1:0] wr_addr_arr_t;
  typedef data_bus_t [DEF_N_WR-1:0] wr_data_arr_t;

  localparam reg_addr_t REG_ZERO = '0;

  // True when addr names the hardwired-zero register in a ZERO_REG build.
  function automatic logic is_zero_reg(input int unsigned addr, input int zero_reg);
    return (zero_reg != 0) && (addr == 0);
  endfunction

endpackage

// File: rtl/mgt01_rf_scoreboard.sv
// Per-register pending scoreboard: reserve sets, writeback clears, reserve wins.
// Forwarded read-out of pending bits under MGT01_REGFILE_BYPASS_EN.
module mgt01_rf_scoreboard
  import mgt01_mp_reg_file_pkg::*;
#(
  parameter int N_REGS   = 32,
  parameter int N_RD     = 2,
  parameter int N_WR     = 2,
  parameter int ZERO_REG = 1,
  parameter int ADDR_W   = $clog2(N_REGS)
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         upd_en_i,
  input  logic                         init_done_i,
  input  logic                         res_en_i,
  input  logic [ADDR_W-1:0]            res_addr_i,
  input  logic [N_WR-1:0]              wr_hit_i,
  input  logic [N_WR-1:0][ADDR_W-1:0]  wr_addr_i,
  input  logic [N_RD-1:0][ADDR_W-1:0]  rd_addr_i,
  output logic [N_RD-1:0]              rd_pending_o
);

  logic [N_REGS-1:0] pend_q;
  logic [N_REGS-1:0] pend_d;

  // Clears applied first so a same-cycle reserve leaves the bit set.
  always_comb begin
    pend_d = pend_q;
    for (int k = 0; k < N_WR; k++) begin
      if (wr_hit_i[k]) pend_d[wr_addr_i[k]] = 1'b0;
    end
    if (res_en_i) pend_d[res_addr_i] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)      pend_q <= '0;
    else if (upd_en_i) pend_q <= pend_d;
  end

  always_comb begin
    rd_pending_o = '0;
    for (int p = 0; p < N_RD; p++) begin
      if (init_done_i && !is_zero_reg(int'(rd_addr_i[p]), ZERO_REG))
        rd_pending_o[p] = pend_q[rd_addr_i[p]];
`ifdef MGT01_REGFILE_BYPASS_EN
      for (int k = 0; k < N_WR; k++) begin
        if (upd_en_i && wr_hit_i[k] && (wr_addr_i[k] == rd_addr_i[p]))
          rd_pending_o[p] = res_en_i && (res_addr_i == rd_addr_i[p]);
      end
`endif
    end
  end

endmodule

// File: rtl/mgt01_mp_reg_file.sv
// Multi-port integer register file with post-reset clear sweep and pending scoreboard.
// Define MGT01_REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module mgt01_mp_reg_file
  import mgt01_mp_reg_file_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int N_REGS   = 32,
  parameter  int N_RD     = 2,
  parameter  int N_WR     = 2,
  parameter  int ZERO_REG = 1,
  localparam int ADDR_W   = $clog2(N_REGS)
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         clk_en_i,
  input  logic [N_RD-1:0][ADDR_W-1:0]  rd_addr_i,
  output logic [N_RD-1:0][DATA_W-1:0]  rd_data_o,
  output logic [N_RD-1:0]              rd_pending_o,
  input  logic [N_WR-1:0]              wr_en_i,
  input  logic [N_WR-1:0][ADDR_W-1:0]  wr_addr_i,
  input  logic [N_WR-1:0][DATA_W-1:0]  wr_data_i,
  input  logic                         res_en_i,
  input  logic [ADDR_W-1:0]            res_addr_i,
  output logic                         init_done_o,
  output logic                         wr_conflict_o
);

  logic [DATA_W-1:0] mem_q [N_REGS];
  logic [ADDR_W-1:0] cnt_q;
  logic              init_done_q;
  logic              conflict_q;
  logic              conflict_d;
  logic [N_WR-1:0]   wr_eff;
  logic              res_eff;
  logic              upd_en;

  assign upd_en = clk_en_i & init_done_q;

  always_comb begin
    wr_eff = '0;
    for (int k = 0; k < N_WR; k++)
      wr_eff[k] = wr_en_i[k] && init_done_q && !is_zero_reg(int'(wr_addr_i[k]), ZERO_REG);
  end

  assign res_eff = res_en_i && init_done_q && !is_zero_reg(int'(res_addr_i), ZERO_REG);

  always_comb begin
    conflict_d = 1'b0;
    for (int i = 0; i < N_WR; i++)
      for (int j = i + 1; j < N_WR; j++)
        if (wr_eff[i] && wr_eff[j] && (wr_addr_i[i] == wr_addr_i[j])) conflict_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      conflict_q  <= 1'b0;
    end else if (clk_en_i) begin
      conflict_q <= conflict_d;
      if (!init_done_q) begin
        cnt_q <= cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(N_REGS - 1)) init_done_q <= 1'b1;
      end
    end
  end

  // Array has no reset; the sweep clears it. Later ports overwrite earlier ones.
  always_ff @(posedge clk_i) begin
    if (clk_en_i) begin
      if (!init_done_q) begin
        mem_q[cnt_q] <= '0;
      end else begin
        for (int k = 0; k < N_WR; k++)
          if (wr_eff[k]) mem_q[wr_addr_i[k]] <= wr_data_i[k];
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int p = 0; p < N_RD; p++) begin
      if (init_done_q && !is_zero_reg(int'(rd_addr_i[p]), ZERO_REG))
        rd_data_o[p] = mem_q[rd_addr_i[p]];
`ifdef MGT01_REGFILE_BYPASS_EN
      for (int k = 0; k < N_WR; k++)
        if (upd_en && wr_eff[k] && (wr_addr_i[k] == rd_addr_i[p]))
          rd_data_o[p] = wr_data_i[k];
`endif
    end
  end

  mgt01_rf_scoreboard #(
    .N_REGS   (N_REGS),
    .N_RD     (N_RD),
    .N_WR     (N_WR),
    .ZERO_REG (ZERO_REG),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .upd_en_i     (upd_en),
    .init_done_i  (init_done_q),
    .res_en_i     (res_eff),
    .res_addr_i   (res_addr_i),
    .wr_hit_i     (wr_eff),
    .wr_addr_i    (wr_addr_i),
    .rd_addr_i    (rd_addr_i),
    .rd_pending_o (rd_pending_o)
  );

  assign init_done_o   = init_done_q;
  assign wr_conflict_o = conflict_q;

endmodule
